hub75_bcm_driver: RTL and testbench

Parametrised successor HUB75 panel driver with binary-coded modulation (BCM) in place of linear PWM compare.
- Double pixel buffer; front/back swap is applied only at frame end (tear-free).
- Global brightness is applied by gating OE.
- Sits on the CPU data bus as a memory-mapped device.
- Drives one HUB75 panel from the single system clock.

---
 rtl/hub75_bcm_driver.sv | 256 +++++++++++++++++++++++++
 tb/tb_hub75_bcm_driver.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_bcm_driver.sv
// HUB75 BCM panel driver: double-buffered pixel RAM on the CPU bus.
// Optional HUB75_GAMMA_EN: gamma-correct colour bytes as they are written.
module hub75_bcm_driver #(
  parameter int          ROWS       = 64,
  parameter int          COLS       = 64,
  parameter int          BPC        = 8,
  parameter int          BASE_TICKS = 8,
  parameter logic [31:0] BASEADDR   = 32'h81000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               addr,
  input  logic [31:0]               wdata,
  input  logic [3:0]                wmask,
  input  logic                      wen,
  input  logic                      ren,
  output logic [31:0]               rdata,
  output logic                      ready,
  output logic                      active,
  output logic                      R0,
  output logic                      G0,
  output logic                      B0,
  output logic                      R1,
  output logic                      G1,
  output logic                      B1,
  output logic [$clog2(ROWS/2)-1:0] ROWSEL,
  output logic                      CLK_HUB75,
  output logic                      LATCH,
  output logic                      OE
);

  localparam int NPIX = ROWS * COLS;
  localparam int AW   = $clog2(2 * NPIX);
  localparam int RW   = $clog2(ROWS / 2);
  localparam int CW   = $clog2(COLS);
  localparam int PW   = (BPC > 1) ? $clog2(BPC) : 1;
  localparam int DMAX = BASE_TICKS << (BPC - 1);
  localparam int DW   = $clog2(DMAX + 1);

  typedef enum logic [2:0] {
    S_FETCH_T,
    S_FETCH_B,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_BLANK,
    S_LATCH,
    S_DISPLAY
  } state_t;

  logic [7:0]    r_mem_r [2*NPIX];
  logic [7:0]    r_mem_g [2*NPIX];
  logic [7:0]    r_mem_b [2*NPIX];

  state_t        r_state;
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic [PW-1:0] r_plane;
  logic [DW-1:0] r_tick;
  logic [23:0]   r_top;
  logic [23:0]   r_bot;
  logic          r_ctrl0;
  logic          r_front;
  logic          r_vsync;
  logic [7:0]    r_bright;

  logic [31:0]   w_off;
  logic [29:0]   w_word;
  logic          w_in_win;
  logic          w_is_pix;
  logic          w_is_ctrl;
  logic          w_is_bright;
  logic [AW-1:0] w_idx;
  logic [AW-1:0] w_scan_addr;
  logic [7:0]    w_in_r;
  logic [7:0]    w_in_g;
  logic [7:0]    w_in_b;
  logic [2:0]    w_bit;
  logic [DW-1:0] w_d;
  logic [DW+8:0] w_prod;
  logic [DW:0]   w_on;
  logic          w_last_tick;
  logic          w_frame_end;
  logic          w_unused;

  assign w_off       = addr - BASEADDR;
  assign w_word      = w_off[31:2];
  assign w_in_win    = (addr >= BASEADDR);
  assign w_is_pix    = w_in_win && (w_word < 30'(2 * NPIX));
  assign w_is_ctrl   = w_in_win && (w_word == 30'(2 * NPIX));
  assign w_is_bright = w_in_win && (w_word == 30'(2 * NPIX + 1));
  assign active      = w_is_pix | w_is_ctrl | w_is_bright;
  assign w_idx       = w_word[AW-1:0];
  assign w_unused    = ^{w_off[1:0], wdata[31:24], wmask[3]};

`ifdef HUB75_GAMMA_EN
  function automatic logic [2047:0] gamma_table();
    logic [2047:0] t;
    real           x;
    t = '0;
    for (int i = 0; i < 256; i++) begin
      x = 255.0 * ((real'(i) / 255.0) ** 2.2);
      t[i*8 +: 8] = 8'($rtoi(x + 0.5));
    end
    return t;
  endfunction

  localparam logic [2047:0] GTAB = gamma_table();

  assign w_in_r = GTAB[{wdata[7:0], 3'b000} +: 8];
  assign w_in_g = GTAB[{wdata[15:8], 3'b000} +: 8];
  assign w_in_b = GTAB[{wdata[23:16], 3'b000} +: 8];
`else
  assign w_in_r = wdata[7:0];
  assign w_in_g = wdata[15:8];
  assign w_in_b = wdata[23:16];
`endif

  // Row index {half, r}: the half bit selects the bottom panel row.
  assign w_scan_addr = {r_front, r_state == S_FETCH_B, r_row, r_col};
  assign w_bit       = 3'(8 - BPC) + 3'(r_plane);
  assign w_d         = DW'(BASE_TICKS) << r_plane;
  assign w_prod      = (DW+9)'(w_d) * (DW+9)'({1'b0, r_bright} + 9'd1);
  assign w_on        = w_prod[DW+8:8];
  assign w_last_tick = (r_tick == w_d - DW'(1));
  assign w_frame_end = (r_state == S_DISPLAY) && w_last_tick &&
                       (r_plane == PW'(BPC - 1)) &&
                       (r_row == RW'(ROWS / 2 - 1));

  // Bus-side pixel writes with per-byte enables; contents survive reset.
  always_ff @(posedge clk) begin
    if (active && wen && w_is_pix) begin
      if (wmask[0]) r_mem_r[w_idx] <= w_in_r;
      if (wmask[1]) r_mem_g[w_idx] <= w_in_g;
      if (wmask[2]) r_mem_b[w_idx] <= w_in_b;
    end
  end

  // Scan-side read port: top row in FETCH_T, bottom row in FETCH_B.
  always_ff @(posedge clk) begin
    if (r_state == S_FETCH_T)
      r_top <= {r_mem_b[w_scan_addr], r_mem_g[w_scan_addr],
                r_mem_r[w_scan_addr]};
    if (r_state == S_FETCH_B)
      r_bot <= {r_mem_b[w_scan_addr], r_mem_g[w_scan_addr],
                r_mem_r[w_scan_addr]};
  end

  // Bus registers, read mux and one-cycle acknowledge; frame end set wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready    <= 1'b0;
      rdata    <= '0;
      r_ctrl0  <= 1'b0;
      r_front  <= 1'b0;
      r_vsync  <= 1'b0;
      r_bright <= 8'hFF;
    end else begin
      ready <= active & (ren | wen);
      rdata <= '0;
      if (active && ren) begin
        unique case (1'b1)
          w_is_pix:
            rdata <= {8'h00, r_mem_b[w_idx], r_mem_g[w_idx],
                      r_mem_r[w_idx]};
          w_is_ctrl:
            rdata <= {22'b0, r_ctrl0 != r_front, r_vsync,
                      7'b0, r_front};
          w_is_bright:
            rdata <= {24'b0, r_bright};
          default:
            rdata <= '0;
        endcase
      end
      if (active && wen && w_is_ctrl) begin
        if (wmask[0]) r_ctrl0 <= wdata[0];
        if (wmask[1] && wdata[8]) r_vsync <= 1'b0;
      end
      if (active && wen && w_is_bright && wmask[0])
        r_bright <= wdata[7:0];
      if (w_frame_end) begin
        r_vsync <= 1'b1;
        r_front <= r_ctrl0;
      end
    end
  end

  // Scan FSM: shift a row pair, blank, latch, then BCM display window.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH_T;
      r_row     <= '0;
      r_col     <= '0;
      r_plane   <= '0;
      r_tick    <= '0;
      OE        <= 1'b1;
      LATCH     <= 1'b0;
      CLK_HUB75 <= 1'b0;
      ROWSEL    <= '0;
      {R0, G0, B0, R1, G1, B1} <= '0;
    end else begin
      OE    <= 1'b1;
      LATCH <= 1'b0;
      unique case (r_state)
        S_FETCH_T: r_state <= S_FETCH_B;
        S_FETCH_B: r_state <= S_SHIFT_LO;
        S_SHIFT_LO: begin
          CLK_HUB75 <= 1'b0;
          R0 <= r_top[5'(w_bit)];
          G0 <= r_top[5'd8 + 5'(w_bit)];
          B0 <= r_top[5'd16 + 5'(w_bit)];
          R1 <= r_bot[5'(w_bit)];
          G1 <= r_bot[5'd8 + 5'(w_bit)];
          B1 <= r_bot[5'd16 + 5'(w_bit)];
          r_state <= S_SHIFT_HI;
        end
        S_SHIFT_HI: begin
          CLK_HUB75 <= 1'b1;
          if (r_col == CW'(COLS - 1)) begin
            r_col   <= '0;
            r_state <= S_BLANK;
          end else begin
            r_col   <= r_col + CW'(1);
            r_state <= S_FETCH_T;
          end
        end
        S_BLANK: begin
          CLK_HUB75 <= 1'b0;
          r_state   <= S_LATCH;
        end
        S_LATCH: begin
          LATCH   <= 1'b1;
          ROWSEL  <= r_row;
          r_tick  <= '0;
          r_state <= S_DISPLAY;
        end
        S_DISPLAY: begin
          OE <= !({1'b0, r_tick} < w_on);
          if (w_last_tick) begin
            r_tick  <= '0;
            r_state <= S_FETCH_T;
            if (r_plane == PW'(BPC - 1)) begin
              r_plane <= '0;
              r_row   <= r_row + RW'(1);
            end else begin
              r_plane <= r_plane + PW'(1);
            end
          end else begin
            r_tick <= r_tick + DW'(1);
          end
        end
        default: r_state <= S_FETCH_T;
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_bcm_driver.sv
// Directed bench for hub75_bcm_driver (4x4 panel, 2 planes, 4 ticks).
// Bus vectors from a table; scan corners as hand-written sequences.
module tb_hub75_bcm_driver;

  localparam logic [31:0] BA = 32'h81000000;
  localparam logic [31:0] CT = BA + 32'h80;
  localparam logic [31:0] BR = BA + 32'h84;
`ifdef HUB75_GAMMA_EN
  localparam logic [7:0] PIX_R = 8'hE0;
`else
  localparam logic [7:0] PIX_R = 8'hC0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wmask = '0;
  logic        wen = 1'b0;
  logic        ren = 1'b0;
  logic [31:0] rdata;
  logic        ready, active;
  logic        R0, G0, B0, R1, G1, B1;
  logic [0:0]  ROWSEL;
  logic        CLK_HUB75, LATCH, OE;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic s_oe [97];
  logic s_lat [97];
  logic s_ck [97];
  logic s_r0 [97];
  logic s_row [97];

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
    bit          we;
    bit          px;
    logic [31:0] e;
  } vec_t;

  vec_t tv [13];

  hub75_bcm_driver #(
    .ROWS(4), .COLS(4), .BPC(2), .BASE_TICKS(4), .BASEADDR(BA)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata),
    .wmask(wmask), .wen(wen), .ren(ren), .rdata(rdata),
    .ready(ready), .active(active),
    .R0(R0), .G0(G0), .B0(B0), .R1(R1), .G1(G1), .B1(B1),
    .ROWSEL(ROWSEL), .CLK_HUB75(CLK_HUB75),
    .LATCH(LATCH), .OE(OE)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst) cyc <= 0;
    else cyc <= cyc + 1;

  function automatic logic [7:0] g8(input logic [7:0] v);
`ifdef HUB75_GAMMA_EN
    real x;
    x = 255.0 * ((real'(v) / 255.0) ** 2.2);
    return 8'($rtoi(x + 0.5));
`else
    return v;
`endif
  endfunction

  function automatic logic [31:0] gpx(input logic [31:0] d);
    return {8'h00, g8(d[23:16]), g8(d[15:8]), g8(d[7:0])};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bus_op(input string nm, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m,
                        input bit we, input bit erdy,
                        output logic [31:0] rd);
    addr = a; wdata = d; wmask = m; wen = we; ren = !we;
    @(negedge clk);
    rd = rdata;
    chk({nm, "_ready"}, 32'(ready), 32'(erdy));
    wen = 1'b0; ren = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    int g = 0;
    while (cyc < n && g < 2000) begin
      @(negedge clk);
      g++;
    end
    chk("wait_cyc", 32'(cyc), 32'(n));
  endtask

  // Reset, optionally write BRIGHT in cycle 1, record one 96-cycle frame.
  task automatic restart(input bit setb, input logic [7:0] bv);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    if (setb) begin
      addr = BR; wdata = {24'b0, bv}; wmask = 4'b0001; wen = 1'b1;
    end
    for (int k = 1; k <= 96; k++) begin
      @(negedge clk);
      wen = 1'b0;
      s_oe[k] = OE; s_lat[k] = LATCH; s_ck[k] = CLK_HUB75;
      s_r0[k] = R0; s_row[k] = ROWSEL[0];
    end
  endtask

  task automatic check_oe(input string nm, input int e0, input int e1);
    int runs[$];
    int len = 0;
    for (int k = 1; k <= 96; k++) begin
      if (!s_oe[k]) len++;
      else if (len > 0) begin runs.push_back(len); len = 0; end
    end
    if (len > 0) runs.push_back(len);
    if (e0 == 0) begin
      chk({nm, "_nruns"}, 32'(runs.size()), 0);
    end else begin
      chk({nm, "_nruns"}, 32'(runs.size()), 4);
      if (runs.size() == 4) begin
        chk({nm, "_r0"}, 32'(runs[0]), 32'(e0));
        chk({nm, "_r1"}, 32'(runs[1]), 32'(e1));
        chk({nm, "_r2"}, 32'(runs[2]), 32'(e0));
        chk({nm, "_r3"}, 32'(runs[3]), 32'(e1));
      end
    end
  endtask

  task automatic check_scan();
    int nrise = 0;
    int nl = 0;
    int first = -1;
    int bad = 0;
    logic prev = 1'b0;
    logic [3:0] rs = '0;
    for (int k = 1; k <= 96; k++) begin
      if (s_ck[k] && !prev) nrise++;
      prev = s_ck[k];
      if (s_lat[k]) begin
        if (first < 0) first = k;
        if (!s_oe[k]) bad++;
        if (nl < 4) rs[nl] = s_row[k];
        nl++;
      end
    end
    chk("clk_rises", 32'(nrise), 16);
    chk("latch_cnt", 32'(nl), 4);
    chk("latch_first", 32'(first), 18);
    chk("latch_oe_low", 32'(bad), 0);
    chk("latch_rows", 32'(rs), 32'h0000000C);
    chk("r0_col0_p0", 32'(s_r0[3]), 1);
    chk("r0_col1_p0", 32'(s_r0[7]), 0);
    chk("r0_col0_p1", 32'(s_r0[25]), 1);
  endtask

  initial begin
    logic [31:0] rd;

    tv[0]  = '{BA+32'h14, 32'h00C08040, 4'b0111, 1, 1, 32'h0};
    tv[1]  = '{BA+32'h14, 32'h0, 4'b0000, 0, 1, 32'h00C08040};
    tv[2]  = '{BA+32'h14, 32'h00000011, 4'b0001, 1, 1, 32'h0};
    tv[3]  = '{BA+32'h14, 32'h0, 4'b0000, 0, 1, 32'h00C08011};
    tv[4]  = '{BA+32'h54, 32'hFFAABBCC, 4'b1111, 1, 1, 32'h0};
    tv[5]  = '{BA+32'h54, 32'h0, 4'b0000, 0, 1, 32'h00AABBCC};
    tv[6]  = '{BR, 32'h0, 4'b0000, 0, 0, 32'h000000FF};
    tv[7]  = '{BR, 32'h00000012, 4'b0001, 1, 0, 32'h0};
    tv[8]  = '{BR, 32'h0, 4'b0000, 0, 0, 32'h00000012};
    tv[9]  = '{BR, 32'h000000FF, 4'b0001, 1, 0, 32'h0};
    tv[10] = '{CT, 32'h0, 4'b0000, 0, 0, 32'h0};
    tv[11] = '{BA+32'h3C, 32'h00123456, 4'b0111, 1, 1, 32'h0};
    tv[12] = '{BA+32'h3C, 32'h0, 4'b0000, 0, 1, 32'h00123456};

    repeat (3) @(negedge clk);
    chk("rst_oe", 32'(OE), 1);
    chk("rst_latch", 32'(LATCH), 0);
    chk("rst_clk", 32'(CLK_HUB75), 0);
    chk("rst_rgb", 32'({R0, G0, B0, R1, G1, B1}), 0);
    chk("rst_rowsel", 32'(ROWSEL), 0);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_rdata", rdata, 0);
    rst = 1'b0;
    @(negedge clk);

    addr = BA + 32'h88; #1 chk("act_above", 32'(active), 0);
    addr = BR;          #1 chk("act_bright", 32'(active), 1);
    addr = BA - 32'h4;  #1 chk("act_below", 32'(active), 0);
    addr = BA + 32'h7C; #1 chk("act_lastpix", 32'(active), 1);

    for (int i = 0; i < 13; i++) begin
      bus_op($sformatf("vec%0d", i), tv[i].a, tv[i].d, tv[i].m,
             tv[i].we, 1'b1, rd);
      if (!tv[i].we)
        chk($sformatf("vec%0d_rdata", i), rd,
            tv[i].px ? gpx(tv[i].e) : tv[i].e);
      @(negedge clk);
      chk($sformatf("vec%0d_rdy_drop", i), 32'(ready), 0);
    end

    bus_op("oow", BA + 32'h88, 32'h0, 4'b0, 0, 1'b0, rd);
    chk("oow_rdata", rd, 0);
    bus_op("b2b_a", BA + 32'h54, 32'h0, 4'b0, 0, 1'b1, rd);
    chk("b2b_a_rdata", rd, gpx(32'h00AABBCC));
    bus_op("b2b_b", BA + 32'h3C, 32'h0, 4'b0, 0, 1'b1, rd);
    chk("b2b_b_rdata", rd, gpx(32'h00123456));

`ifdef HUB75_GAMMA_EN
    bus_op("gam_w", BA + 32'h14, 32'h80, 4'b0001, 1, 1'b1, rd);
    bus_op("gam_r", BA + 32'h14, 32'h0, 4'b0, 0, 1'b1, rd);
    chk("gamma_128", 32'(rd[7:0]), 32'h38);
`endif

    for (int p = 0; p < 16; p++)
      bus_op("clr", BA + 32'(4 * p), (p == 0) ? {24'b0, PIX_R} : 32'h0,
             4'b0111, 1, 1'b1, rd);
    bus_op("clr1", BA + 32'h40, 32'h0, 4'b0111, 1, 1'b1, rd);

    restart(1'b0, 8'h00);
    check_scan();
    check_oe("oe255", 4, 8);
    restart(1'b1, 8'd127);
    check_oe("oe127", 2, 4);
    restart(1'b1, 8'd0);
    check_oe("oe0", 0, 0);

    do_reset();
    bus_op("ctrl_w1", CT, 32'h1, 4'b0001, 1, 1'b1, rd);
    bus_op("ctrl_r1", CT, 32'h0, 4'b0, 0, 1'b1, rd);
    chk("ctrl_pending", rd, 32'h00000200);
    wait_cyc(25);
    chk("front0_r0", 32'(R0), 1);
    wait_cyc(96);
    bus_op("ctrl_r2", CT, 32'h0, 4'b0, 0, 1'b1, rd);
    chk("ctrl_swapped", rd, 32'h00000101);
    wait_cyc(99);
    chk("front1_r0", 32'(R0), 0);
    bus_op("vs_clr", CT, 32'h101, 4'b0011, 1, 1'b1, rd);
    bus_op("ctrl_r3", CT, 32'h0, 4'b0, 0, 1'b1, rd);
    chk("vsync_clr", rd, 32'h00000001);
    wait_cyc(191);
    bus_op("fe_w", CT, 32'h100, 4'b0011, 1, 1'b1, rd);
    bus_op("ctrl_r4", CT, 32'h0, 4'b0, 0, 1'b1, rd);
    chk("fe_set_wins", rd, 32'h00000301);
    wait_cyc(288);
    bus_op("ctrl_r5", CT, 32'h0, 4'b0, 0, 1'b1, rd);
    chk("fe_late_swap", rd, 32'h00000100);

    do_reset();
    wait_cyc(67);
    chk("pre_oe", 32'(OE), 0);
    chk("pre_rowsel", 32'(ROWSEL), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_oe", 32'(OE), 1);
    chk("mid_latch", 32'(LATCH), 0);
    chk("mid_rowsel", 32'(ROWSEL), 0);
    chk("mid_clk", 32'(CLK_HUB75), 0);
    restart(1'b0, 8'h00);
    chk("re_latch_first", 32'(s_lat[18]), 1);
    chk("re_row0", 32'(s_row[18]), 0);
    chk("re_r0", 32'(s_r0[3]), 1);
    bus_op("keep", BA + 32'h54, 32'h0, 4'b0, 0, 1'b1, rd);
    chk("ram_kept", rd, gpx(32'h00AABBCC));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
